// File: rtl/ins_cache_dm_r32i.sv
// ins_cache_dm_r32i: direct-mapped instruction cache for the RV32I core.
// It sits between the PC fetch port and the shared RAM read port. A hit returns
// the instruction in the same cycle. A miss stalls the PC while a refill FSM
// burst-reads one whole line, one word per accepted beat. Flush invalidates
// every line.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   ProgAddr              fetch byte address (bits [1:0] ignored)
//   Flush                 single-cycle pulse, invalidates all lines
//   OutputIns             instruction at ProgAddr (0 when not a hit)
//   InsCacheStall         1 = instruction not available, PC must hold
//   MemReq / MemAddr      refill read request and word-aligned byte address
//   MemRdata / MemValid   refill data and beat-accepted strobe
//   HitCount / MissCount  saturating statistics counters (ICACHE_STATS_EN only)
//
// Optional feature: define ICACHE_STATS_EN to add HitCount and MissCount.

module ins_cache_dm_r32i #(
  parameter int unsigned dataW        = 32,
  parameter int unsigned AddrW        = 32,
  parameter int unsigned Lines        = 16,
  parameter int unsigned WordsPerLine = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AddrW-1:0] ProgAddr,
  input  logic             Flush,
  output logic [dataW-1:0] OutputIns,
  output logic             InsCacheStall,
  output logic             MemReq,
  output logic [AddrW-1:0] MemAddr,
  input  logic [dataW-1:0] MemRdata,
`ifdef ICACHE_STATS_EN
  output logic [31:0]      HitCount,
  output logic [31:0]      MissCount,
`endif
  input  logic             MemValid
);

  localparam int unsigned OffW  = $clog2(WordsPerLine);
  localparam int unsigned IdxW  = $clog2(Lines);
  localparam int unsigned TagW  = AddrW - IdxW - OffW - 2;
  localparam int unsigned BaseW = TagW + IdxW;

  typedef enum logic {StIdle, StRefill} stateT;

  stateT stateQ, stateD;

  // Fetch address fields
  logic [OffW-1:0] off;
  logic [IdxW-1:0] idx;
  logic [TagW-1:0] tag;
  logic            unusedAddr;

  assign off        = ProgAddr[OffW+1:2];
  assign idx        = ProgAddr[OffW+IdxW+1:OffW+2];
  assign tag        = ProgAddr[AddrW-1:AddrW-TagW];
  assign unusedAddr = ^ProgAddr[1:0];

  // Storage
  logic [dataW-1:0] dataQ [Lines][WordsPerLine];
  logic [TagW-1:0]  tagQ  [Lines];
  logic [Lines-1:0] validQ;

  // Refill bookkeeping: {tag, idx} of the line being filled, and beat counter
  logic [BaseW-1:0] refillBaseQ;
  logic [OffW-1:0]  cntQ;
  logic [IdxW-1:0]  refillIdx;
  logic [TagW-1:0]  refillTag;

  assign refillIdx = refillBaseQ[IdxW-1:0];
  assign refillTag = refillBaseQ[BaseW-1:IdxW];

  logic lineMatch, hit, startRefill, beat, lastBeat;

  assign lineMatch   = validQ[idx] && (tagQ[idx] == tag);
  assign hit         = lineMatch && (stateQ == StIdle) && !Flush;
  // Flush wins over a same-cycle miss and over a same-cycle refill beat.
  assign startRefill = (stateQ == StIdle) && !Flush && !lineMatch;
  assign beat        = (stateQ == StRefill) && MemValid && !Flush;
  assign lastBeat    = beat && (cntQ == OffW'(WordsPerLine - 1));

  assign InsCacheStall = !hit;

  always_comb begin
    OutputIns = '0;
    if (hit) begin
      OutputIns = dataQ[idx][off];
    end
  end

  // FSM: state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // FSM: next state
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:   if (startRefill) stateD = StRefill;
      StRefill: if (Flush || lastBeat) stateD = StIdle;
      default:  stateD = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    MemReq  = 1'b0;
    MemAddr = '0;
    unique case (stateQ)
      StRefill: begin
        MemReq  = 1'b1;
        MemAddr = {refillBaseQ, cntQ, 2'b00};
      end
      default: begin
        MemReq  = 1'b0;
        MemAddr = '0;
      end
    endcase
  end

  // Valid bits and refill bookkeeping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      validQ      <= '0;
      cntQ        <= '0;
      refillBaseQ <= '0;
    end else if (Flush) begin
      validQ <= '0;
    end else if (startRefill) begin
      // Invalidate up front so an aborted refill never leaves a stale hit.
      validQ[idx] <= 1'b0;
      refillBaseQ <= {tag, idx};
      cntQ        <= '0;
    end else if (beat) begin
      cntQ <= cntQ + OffW'(1);
      if (lastBeat) begin
        validQ[refillIdx] <= 1'b1;
      end
    end
  end

  // Data and tag arrays are not reset; the valid bits guard them.
  always_ff @(posedge clock) begin
    if (beat) begin
      dataQ[refillIdx][cntQ] <= MemRdata;
      if (lastBeat) begin
        tagQ[refillIdx] <= refillTag;
      end
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hitCountQ, missCountQ;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hitCountQ  <= '0;
      missCountQ <= '0;
    end else begin
      if (hit && (hitCountQ != '1)) begin
        hitCountQ <= hitCountQ + 32'd1;
      end
      if (startRefill && (missCountQ != '1)) begin
        missCountQ <= missCountQ + 32'd1;
      end
    end
  end

  assign HitCount  = hitCountQ;
  assign MissCount = missCountQ;
`endif

endmodule

// File: tb/tb_ins_cache_dm_r32i.sv
// Self-checking bench for ins_cache_dm_r32i (default parameters). A small
// line-level model (valid/tag per index) predicts hit or miss; a miss is
// expected to burst-read the line base upward, one word per accepted beat.
module tb_ins_cache_dm_r32i;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ProgAddr = '0;
  logic        Flush = 1'b0;
  logic [31:0] OutputIns;
  logic        InsCacheStall;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic [31:0] MemRdata;
  logic        MemValid = 1'b0;
`ifdef ICACHE_STATS_EN
  logic [31:0] HitCount, MissCount;
`endif

  ins_cache_dm_r32i dut (
    .clock        (clock),
    .reset        (reset),
    .ProgAddr     (ProgAddr),
    .Flush        (Flush),
    .OutputIns    (OutputIns),
    .InsCacheStall(InsCacheStall),
    .MemReq       (MemReq),
    .MemAddr      (MemAddr),
    .MemRdata     (MemRdata),
`ifdef ICACHE_STATS_EN
    .HitCount     (HitCount),
    .MissCount    (MissCount),
`endif
    .MemValid     (MemValid)
  );

  always #5 clock = ~clock;

  // Backing memory: words 0..3 hold 0xA0+n, everything else a hash of the address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a < 32'h10) return 32'hA0 + (a >> 2);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  always_comb MemRdata = memWord(MemAddr);

  int nChecks = 0;
  int nErrors = 0;

  task automatic checkEq(input string tagName, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tagName, got, exp, $time);
    end
  endtask

  // Line-level model
  bit          mValid [16];
  logic [23:0] mTag   [16];
  int          expHits;
  int          expMisses;
  bit          vpat[$];

  task automatic modelClear();
    for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    Flush = 1'b0;
    MemValid = 1'b0;
    modelClear();
    expHits = 0;
    expMisses = 0;
    @(negedge clock);
    checkEq("rstStall", InsCacheStall, 1);
    checkEq("rstReq", MemReq, 0);
    checkEq("rstAddr", MemAddr, 0);
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic doFlush(input logic [31:0] a);
    ProgAddr = a;
    Flush = 1'b1;
    MemValid = 1'($urandom_range(1));
    @(negedge clock);
    checkEq("flushStall", InsCacheStall, 1);
    @(posedge clock);
    #1;
    Flush = 1'b0;
    MemValid = 1'b0;
    modelClear();
  endtask

  // One fetch: a hit takes one cycle; a miss takes an idle cycle, the refill
  // beats, then the hit cycle. stallSeen counts cycles observed with stall=1.
  task automatic doFetch(input logic [31:0] a, input int validPct, output int stallSeen);
    int idx;
    logic [23:0] tg;
    logic [31:0] base;
    int k;
    int cyc;
    idx = int'((a >> 4) & 32'hF);
    tg = a[31:8];
    base = a & ~32'hF;
    stallSeen = 0;
    ProgAddr = a;
    Flush = 1'b0;
    MemValid = 1'b0;
    if (!(mValid[idx] && mTag[idx] == tg)) begin
      expMisses++;
      @(negedge clock);
      stallSeen += int'(InsCacheStall);
      checkEq("missStall", InsCacheStall, 1);
      checkEq("missIdleReq", MemReq, 0);
      checkEq("missIdleAddr", MemAddr, 0);
      @(posedge clock);
      #1;
      mValid[idx] = 1'b0;
      k = 0;
      cyc = 0;
      while (k < 4) begin
        if (cyc > 200) begin
          checkEq("refillTimeout", 0, 1);
          break;
        end
        if (vpat.size() > 0) MemValid = vpat.pop_front();
        else MemValid = ($urandom_range(99) < validPct);
        @(negedge clock);
        stallSeen += int'(InsCacheStall);
        checkEq("refillStall", InsCacheStall, 1);
        checkEq("refillReq", MemReq, 1);
        checkEq("refillAddr", MemAddr, base + 32'(4 * k));
        @(posedge clock);
        if (MemValid) k++;
        cyc++;
        #1;
      end
      MemValid = 1'b0;
      mValid[idx] = 1'b1;
      mTag[idx] = tg;
    end
    expHits++;
    @(negedge clock);
    stallSeen += int'(InsCacheStall);
    checkEq("hitStall", InsCacheStall, 0);
    checkEq("hitData", OutputIns, memWord(a & ~32'h3));
    checkEq("hitReq", MemReq, 0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    logic [31:0] a;

    // Cold miss with MemValid held high: 1+WordsPerLine stall cycles.
    doReset();
    doFetch(32'h00, 100, st);
    checkEq("coldStallLen", 32'(st), 5);
    doFetch(32'h04, 100, st);
    checkEq("hit4Stall", 32'(st), 0);
    doFetch(32'h08, 100, st);
    doFetch(32'h0C, 100, st);
    checkEq("hitCStall", 32'(st), 0);

    // Conflict eviction: same index, different tag.
    doFetch(32'h100, 100, st);
    checkEq("evictFillLen", 32'(st), 5);
    doFetch(32'h000, 100, st);
    checkEq("evictRemiss", 32'(st != 0), 1);

    // Backpressure 1,0,0,1,1,1: address holds during gaps, 7 stall cycles.
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    doFetch(32'h240, 100, st);
    checkEq("bpStallLen", 32'(st), 7);

    // Flush after two accepted words aborts the refill.
    doReset();
    ProgAddr = 32'h0;
    MemValid = 1'b1;
    @(posedge clock);
    #1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      checkEq("preFlushAddr", MemAddr, 32'(4 * k));
      @(posedge clock);
      #1;
    end
    Flush = 1'b1;
    @(negedge clock);
    checkEq("flushBeatReq", MemReq, 1);
    @(posedge clock);
    #1;
    Flush = 1'b0;
    MemValid = 1'b0;
    @(negedge clock);
    checkEq("postFlushReq", MemReq, 0);
    checkEq("postFlushStall", InsCacheStall, 1);
    @(posedge clock);
    #1;
    for (int k = 0; k < 4; k++) begin
      MemValid = 1'b1;
      @(negedge clock);
      checkEq("refetchReq", MemReq, 1);
      checkEq("refetchAddr", MemAddr, 32'(4 * k));
      @(posedge clock);
      #1;
    end
    MemValid = 1'b0;
    @(negedge clock);
    checkEq("refetchStall", InsCacheStall, 0);
    checkEq("refetchData", OutputIns, 32'hA0);
    @(posedge clock);
    #1;

    // Reset in the middle of a refill drops MemReq at once.
    doReset();
    ProgAddr = 32'h340;
    MemValid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    checkEq("midRstReq", MemReq, 0);
    checkEq("midRstStall", InsCacheStall, 1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    MemValid = 1'b0;
    modelClear();
    doFetch(32'h340, 100, st);
    checkEq("postRstRefill", 32'(st), 5);

`ifdef ICACHE_STATS_EN
    doReset();
    doFetch(32'h00, 100, st);
    doFetch(32'h04, 100, st);
    doFetch(32'h08, 100, st);
    doFetch(32'h0C, 100, st);
    #1;
    checkEq("statHits", HitCount, 4);
    checkEq("statMisses", MissCount, 1);
    reset = 1'b1;
    #1;
    checkEq("statHitsRst", HitCount, 0);
    checkEq("statMissesRst", MissCount, 0);
`endif

    // Randomized fetches over 4 tags x 16 lines with occasional flushes.
    doReset();
    for (int i = 0; i < 150; i++) begin
      a = (32'($urandom_range(3)) << 8) | (32'($urandom_range(15)) << 4)
        | (32'($urandom_range(3)) << 2);
      if ($urandom_range(99) < 6) doFlush(a);
      else doFetch(a, int'($urandom_range(100, 30)), st);
    end
`ifdef ICACHE_STATS_EN
    #1;
    checkEq("randHits", HitCount, 32'(expHits));
    checkEq("randMisses", MissCount, 32'(expMisses));
`endif

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/ins_cache_dm_r32i.md
Name: ins_cache_dm_r32i

Overview:
Parametrised direct-mapped instruction cache for the RV32I core. It replaces the fixed single-line instruction cache and sits between the PC (ProgAddr / InsCacheStall) and the shared RAM port. Hits return the instruction in the same cycle. Misses stall the PC while a refill FSM burst-reads one full line from memory, one word per accepted beat. A flush input invalidates the whole cache.

Parameters:
dataW, 32, instruction/data word width
AddrW, 32, byte address width
Lines, 16, number of cache lines (power of 2, >=2)
WordsPerLine, 4, words per line (power of 2, >=2)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
ProgAddr  in  AddrW  fetch byte address from PC; bits [1:0] ignored
Flush  in  1  invalidate all lines (single-cycle pulse)
OutputIns  out  dataW  instruction at ProgAddr; valid when InsCacheStall=0
InsCacheStall  out  1  1 = instruction not available, PC must hold
MemReq  out  1  refill read request
MemAddr  out  AddrW  word-aligned refill byte address
MemRdata  in  dataW  memory read data
MemValid  in  1  MemRdata valid this cycle, request accepted

Behaviour:
- Address split: off = ProgAddr[1+log2(WordsPerLine):2]; idx = next log2(Lines) bits; tag = remaining upper bits.
- Storage: data array Lines x WordsPerLine x dataW; tag array; valid bit per line. All are flops.
- Hit = valid[idx] && tag[idx]==tag && state==IDLE && !Flush. Evaluated combinationally.
- OutputIns = data[idx][off] combinationally. Value is don't-care when stalled; it drives 0 when not hit.
- InsCacheStall = !Hit. This is combinational, so it is 1 throughout reset and after any invalidate.
- FSM states: IDLE, REFILL.
- IDLE: on a miss (and no Flush), at the clock edge latch line base {tag,idx} into RefillBase, clear Cnt, clear valid[idx], go to REFILL.
- REFILL: MemReq=1; MemAddr = {RefillBase, Cnt, 2'b00}.
  - Each edge with MemValid=1: write MemRdata into data[RefillIdx][Cnt], then Cnt++.
  - On the edge accepting word WordsPerLine-1: write tag, set valid, Cnt wraps to 0, go to IDLE.
  - MemValid=0: hold state and Cnt; MemAddr stays stable.
- IDLE outputs: MemReq=0, MemAddr=0.
- Latency: with MemValid held at 1, a miss stalls for exactly 1+WordsPerLine cycles. The following cycle is a hit.
- ProgAddr must be stable while InsCacheStall=1. The refill uses the latched base regardless.
- Flush: clears all valid bits at the edge. In REFILL, Flush aborts: go to IDLE, no tag write, line left invalid, and any MemValid that cycle is ignored. Flush overrides a same-cycle miss, so no refill starts.
- Reset (async): state=IDLE, Cnt=0, all valid=0, MemReq=0, MemAddr=0. Data and tag arrays are not reset.
- Reset mid-refill: immediate return to IDLE with MemReq=0; the partially filled line stays invalid.
- Cnt width = log2(WordsPerLine). Wrap from WordsPerLine-1 to 0 is natural overflow.

Optional Feature:
ICACHE_STATS_EN.
- Defined: adds outputs HitCount and MissCount (32 bits each).
  - HitCount increments on each cycle with Hit=1.
  - MissCount increments on each IDLE->REFILL transition.
  - Both saturate at 0xFFFFFFFF.
  - Both are reset to 0 by reset only; Flush does not clear them.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Cold miss, defaults: reset, ProgAddr=0x00, MemValid=1, memory returns 0xA0+n for word n.
  - Required: InsCacheStall=1 for 5 cycles.
  - Required: MemAddr sequence 0x00,0x04,0x08,0x0C.
  - Required: then OutputIns=0xA0 with stall=0.
- Hit after fill: ProgAddr 0x04, 0x08, 0x0C.
  - Required: stall=0, OutputIns 0xA1, 0xA2, 0xA3, MemReq=0.
- Conflict eviction: fill 0x000, then fetch 0x100 (same idx, different tag).
  - Required: refill from 0x100–0x10C.
  - Required: a later fetch of 0x000 misses again.
- Memory backpressure: MemValid pattern 1,0,0,1,1,1.
  - Required: MemAddr holds during the 0s.
  - Required: stall lasts 7 cycles.
  - Required: data is correct.
- Flush mid-refill: Flush after 2 words.
  - Required: next cycle IDLE, MemReq=0.
  - Required: refetch of same address starts a fresh 4-word refill from 0x00.
- ICACHE_STATS_EN: cold miss plus 3 hits.
  - Required: MissCount=1, HitCount=4 (including the post-fill cycle).
  - Required: reset returns both to 0.
